// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - two-requester arbiter for one shared countdown timer
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req0, req1        requests, held until done or dropped to abort
//   init0, init1      count values, captured when the request is granted
//   timer_out         current count of the shared timer
//   timer_load        load the shared timer with timer_init
//   timer_en          let the shared timer count down
//   timer_init        load value, zero except while timer_load is high
//   gnt0, gnt1        current owner of the timer (one-hot or zero)
//   done0, done1      one-cycle pulse when the owner's count has expired
//   busy              arbiter is outside IDLE
//
// Build option: ROUND_ROBIN_EN - simultaneous requests alternate between the
// requesters; when undefined req0 always wins a tie.

module timer_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] init0,
    input  logic [3:0] init1,
    input  logic [3:0] timer_out,
    output logic       timer_load,
    output logic       timer_en,
    output logic [3:0] timer_init,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic       owner;
    logic [3:0] init_q;
    logic       winner;
    logic [3:0] winner_init;
    logic       owner_req;

`ifdef ROUND_ROBIN_EN
    // Requester served most recently; a tie goes to the other one.
    logic       last_served;
`endif

    always_comb begin
`ifdef ROUND_ROBIN_EN
        if (req0 && req1) begin
            winner = ~last_served;
        end else begin
            winner = ~req0;
        end
`else
        winner = ~req0;
`endif
        winner_init = winner ? init1 : init0;
        owner_req   = owner ? req1 : req0;
    end

    // The latched count is only presented while the timer is being loaded.
    assign timer_init = timer_load ? init_q : 4'd0;

    // Outputs are registered: each transition sets the values that belong to
    // the state being entered, so they always match the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            init_q      <= 4'd0;
`ifdef ROUND_ROBIN_EN
            last_served <= 1'b1;
`endif
            timer_load  <= 1'b0;
            timer_en    <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            timer_load <= 1'b0;
            timer_en   <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state       <= LOAD;
                        owner       <= winner;
                        init_q      <= winner_init;
`ifdef ROUND_ROBIN_EN
                        last_served <= winner;
`endif
                        timer_load  <= 1'b1;
                        gnt0        <= ~winner;
                        gnt1        <= winner;
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= RUN;
                    timer_en <= 1'b1;
                end
                RUN: begin
                    // A dropped request aborts even when the count has just
                    // reached zero, so no done pulse is produced.
                    if (!owner_req) begin
                        state <= IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (timer_out == 4'd0) begin
                        state <= DONE;
                        done0 <= ~owner;
                        done1 <= owner;
                    end else begin
                        timer_en <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - scoreboard bench for timer_arbiter

module tb_timer_arbiter;

    localparam int EV_LOAD = 0;
    localparam int EV_DONE = 1;
    localparam int EV_END  = 2;

    typedef struct {
        int kind;
        int owner;
        int init;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] init0 = 4'd0;
    logic [3:0] init1 = 4'd0;
    logic [3:0] timer_out = 4'd0;
    logic       timer_load;
    logic       timer_en;
    logic [3:0] timer_init;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       busy;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  last_served = 1;
    bit  prev_busy = 1'b0;
    ev_t exp_q[$];

    timer_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .init0      (init0),
        .init1      (init1),
        .timer_out  (timer_out),
        .timer_load (timer_load),
        .timer_en   (timer_en),
        .timer_init (timer_init),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared countdown timer owned by the environment.
    always @(posedge clk) begin
        if (timer_load) begin
            timer_out <= timer_init;
        end else if (timer_en && timer_out != 4'd0) begin
            timer_out <= timer_out - 4'd1;
        end
    end

    function automatic string kname(int k);
        if (k == EV_LOAD) return "load";
        if (k == EV_DONE) return "done";
        return "end";
    endfunction

    // Arbitration rule: a lone requester wins; a tie goes to req0, or with
    // round robin to whoever was not served last.
    function automatic int choose(bit a, bit b);
        if (a && b) begin
`ifdef ROUND_ROBIN_EN
            return (last_served == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return a ? 0 : 1;
    endfunction

    task automatic push(int kind, int owner, int init, int at);
        ev_t e;
        e.kind  = kind;
        e.owner = owner;
        e.init  = init;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(int kind, int owner, int init);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected %s owner=%0d init=%0d at cycle %0d, none expected",
                     kname(kind), owner, init, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind != EV_END && e.owner != owner) ||
            (kind == EV_LOAD && e.init != init)) begin
            errors++;
            $display("FAIL event: got %s owner=%0d init=%0d cycle=%0d, expected %s owner=%0d init=%0d cycle=%0d",
                     kname(kind), owner, init, cyc, kname(e.kind), e.owner, e.init, e.cyc);
        end
    endtask

    // Monitor: observes the DUT away from the active edge and pops the
    // scoreboard on every load, done pulse and return to idle.
    always @(negedge clk) begin
        int o;
        o = (gnt0 && !gnt1) ? 0 : ((gnt1 && !gnt0) ? 1 : -1);
        if (timer_load) check_event(EV_LOAD, o, int'(timer_init));
        if (done0 || done1) check_event(EV_DONE, (done1 && !done0 && o == 1) ? 1 :
                                                  ((done0 && !done1 && o == 0) ? 0 : -1), 0);
        if (prev_busy && !busy) check_event(EV_END, 0, 0);
        checks++;
        if ((gnt0 && gnt1) || (!timer_load && timer_init != 4'd0) ||
            (timer_load && timer_en) || (busy != (gnt0 | gnt1)) ||
            ((done0 || done1) && timer_en)) begin
            errors++;
            $display("FAIL invariant: cycle %0d load=%0b en=%0b init=%0d gnt=%0b%0b done=%0b%0b busy=%0b",
                     cyc, timer_load, timer_en, timer_init, gnt1, gnt0, done1, done0, busy);
        end
        prev_busy = busy;
    end

    task automatic at_cycle(int n);
        int guard = 0;
        while (cyc < n && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, n);
        end
    endtask

    task automatic set_req(int w, bit v);
        if (w == 0) req0 = v;
        else req1 = v;
    endtask

    // One arbitration round starting in an IDLE cycle. The winner may abort
    // after abort_k RUN cycles (-1: run to completion); a losing requester
    // keeps requesting and is served right after.
    task automatic round(bit r0, bit r1, int i0, int i1, int abort_k, int new_init);
        int n, w, l, iw, il, e, d;
        n = cyc;
        req0 = r0;
        req1 = r1;
        init0 = 4'(i0);
        init1 = 4'(i1);
        w = choose(r0, r1);
        last_served = w;
        iw = (w == 0) ? i0 : i1;
        il = (w == 0) ? i1 : i0;
        if (abort_k > iw) abort_k = -1;
        push(EV_LOAD, w, iw, n + 1);
        at_cycle(n + 2);
        if (w == 0) init0 = (new_init < 0) ? 4'($urandom) : 4'(new_init);
        else        init1 = (new_init < 0) ? 4'($urandom) : 4'(new_init);
        if (abort_k >= 0) begin
            e = n + 3 + abort_k;
            push(EV_END, 0, 0, e);
            at_cycle(n + 2 + abort_k);
            set_req(w, 1'b0);
        end else begin
            d = n + 3 + iw;
            e = d + 1;
            push(EV_DONE, w, 0, d);
            push(EV_END, 0, 0, e);
            at_cycle(d);
            set_req(w, 1'b0);
        end
        if (r0 && r1) begin
            l = 1 - w;
            last_served = l;
            push(EV_LOAD, l, il, e + 1);
            d = e + 3 + il;
            push(EV_DONE, l, 0, d);
            push(EV_END, 0, 0, d + 1);
            at_cycle(d);
            set_req(l, 1'b0);
            e = d + 1;
        end
        at_cycle(e);
        at_cycle(e + int'($urandom_range(0, 2)));
    endtask

    // Both requesters held for several back-to-back grants.
    task automatic both_held(int i0, int i1, int grants);
        int n, w, iw, d;
        n = cyc;
        req0 = 1'b1;
        req1 = 1'b1;
        init0 = 4'(i0);
        init1 = 4'(i1);
        for (int g = 0; g < grants; g++) begin
            w = choose(1'b1, 1'b1);
            last_served = w;
            iw = (w == 0) ? i0 : i1;
            push(EV_LOAD, w, iw, n + 1);
            d = n + 3 + iw;
            push(EV_DONE, w, 0, d);
            push(EV_END, 0, 0, d + 1);
            n = d + 1;
        end
        at_cycle(n - 1);
        req0 = 1'b0;
        req1 = 1'b0;
        at_cycle(n);
    endtask

    // Reset asserted mid-RUN while the timer reads 5.
    task automatic reset_mid_run();
        int n;
        n = cyc;
        req0 = 1'b1;
        req1 = 1'b0;
        init0 = 4'd9;
        last_served = 0;
        push(EV_LOAD, 0, 9, n + 1);
        at_cycle(n + 6);
        checks++;
        if (timer_out != 4'd5) begin
            errors++;
            $display("FAIL reset_run_count: timer_out=%0d, expected 5", timer_out);
        end
        #1;
        push(EV_END, 0, 0, n + 6);
        rst = 1'b1;
        #1;
        checks++;
        if ({timer_load, timer_en, timer_init, gnt0, gnt1, done0, done1, busy} != 11'd0) begin
            errors++;
            $display("FAIL reset_mid_run: outputs load=%0b en=%0b init=%0d gnt=%0b%0b done=%0b%0b busy=%0b, expected all 0",
                     timer_load, timer_en, timer_init, gnt1, gnt0, done1, done0, busy);
        end
        req0 = 1'b0;
        last_served = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy || gnt0 || gnt1 || timer_en || timer_load) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b gnt=%0b%0b en=%0b load=%0b, expected all 0",
                     busy, gnt1, gnt0, timer_en, timer_load);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, k, guard;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({timer_load, timer_en, timer_init, gnt0, gnt1, done0, done1, busy} != 11'd0) begin
            errors++;
            $display("FAIL reset_state: load=%0b en=%0b init=%0d gnt=%0b%0b done=%0b%0b busy=%0b, expected all 0",
                     timer_load, timer_en, timer_init, gnt1, gnt0, done1, done0, busy);
        end
        rst = 1'b0;

        round(1'b1, 1'b0, 3, 0, -1, -1);   // done0 six cycles after the request
        round(1'b1, 1'b0, 0, 0, -1, -1);   // zero count: a single RUN cycle
        both_held(2, 2, 3);                // tie handling over three grants
        round(1'b0, 1'b1, 0, 9, 2, -1);    // req1 aborts in its third RUN cycle
        round(1'b1, 1'b0, 4, 0, -1, 12);   // init changed to 12 after grant
        round(1'b1, 1'b0, 2, 0, 2, -1);    // abort in the same cycle as expiry
        round(1'b1, 1'b1, 5, 3, -1, -1);   // simultaneous one-shot requests
        round(1'b0, 1'b1, 15, 7, -1, -1);  // maximum count
        reset_mid_run();

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(1, 3));
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            round(r[0], r[1], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), k, -1);
        end
        both_held(1, 3, 4);

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing: expected %s owner=%0d init=%0d at cycle %0d never seen",
                     kname(e.kind), e.owner, e.init, e.cyc);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: req0  input  1  requester 0 wants the shared countdown timer; held high until done0 or abort.
REQ-004 SHALL have port: req1  input  1  requester 1 wants the shared countdown timer; same rules as req0.
REQ-005 SHALL have port: init0  input  4  requester 0 count value; sampled only on grant.
REQ-006 SHALL have port: init1  input  4  requester 1 count value; sampled only on grant.
REQ-007 SHALL have port: timer_out  input  4  current count from shared timer; timer loads on timer_load, decrements by 1 per cycle while timer_en and nonzero.
REQ-008 SHALL have port: timer_load  output  1  load shared timer with timer_init.
REQ-009 SHALL have port: timer_en  output  1  enable shared timer decrement.
REQ-010 SHALL have port: timer_init  output  4  load value for shared timer.
REQ-011 SHALL have port: gnt0, gnt1  output  1 each  requester owns timer; one-hot or zero.
REQ-012 SHALL have port: done0, done1  output  1 each  one-cycle pulse when owner's count expired.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DONE; outputs decoded from state, owner and latched init registers (Moore).
REQ-015 IDLE: timer_load=0, timer_en=0, gnt*=0; if any req, select winner, latch owner and its init, go LOAD next cycle; else stay.
REQ-016 LOAD: timer_load=1, timer_init=latched init, timer_en=0, gnt[owner]=1; unconditionally go RUN.
REQ-017 RUN: timer_en=1, timer_load=0, gnt[owner]=1; timer_out==0 -> DONE; owner req low (abort) -> IDLE with no done pulse; abort takes priority over expiry in the same cycle.
REQ-018 DONE: done[owner]=1 for exactly one cycle, gnt[owner]=1, timer_en=0; go IDLE.
REQ-019 Latency: req sampled in IDLE cycle N -> timer_load at N+1 -> RUN from N+2 -> done at N+3+init.
REQ-020 init=0 SHALL yield one RUN cycle then DONE (done at N+3).
REQ-021 init0/init1 changes after grant SHALL NOT affect the running count.
REQ-022 Requester still requesting after DONE re-enters arbitration in IDLE like any new request; minimum one IDLE cycle between grants.
REQ-023 Non-owner req changes during LOAD/RUN/DONE SHALL be ignored until IDLE.
REQ-024 timer_init SHALL read 4'b0000 in all states other than LOAD.

Reset
REQ-025 On rst high, immediately (asynchronous): state=IDLE, owner=0, last-served pointer=1 (req0 favoured), latched init=0.
REQ-026 During and after reset all outputs SHALL be 0 until a request is accepted; reset mid-RUN SHALL drop timer_en and gnt without done pulse.

Configuration
REQ-027 Macro ROUND_ROBIN_EN defined: simultaneous req0 and req1 in IDLE grant the requester not served last; last-served pointer updates on entry to LOAD.
REQ-028 Macro ROUND_ROBIN_EN undefined: fixed priority, req0 always wins ties; pointer register absent.
REQ-029 Single-requester behaviour SHALL be identical in both configurations.

Verification
REQ-030 Reset release, req0=1 init0=3, timer model -> timer_load at cycle 1 with timer_init=3, timer_out 3,2,1,0 in RUN, done0 single pulse at cycle 6, busy low at cycle 7.
REQ-031 req0=1 init0=0 -> done0 at cycle 3, timer_en high exactly one cycle.
REQ-032 req0 and req1 both held, init=2 each, ROUND_ROBIN_EN defined -> grants alternate 0,1,0; undefined -> gnt0 every time, gnt1 never.
REQ-033 req1 granted init1=9, drop req1 at 3rd RUN cycle -> IDLE next cycle, done1 never pulses, timer_en low.
REQ-034 Assert rst during RUN with timer_out=5 -> all outputs 0 same cycle; after release with no req, stays IDLE.
REQ-035 Change init0 from 4 to 12 during RUN -> count completes from 4; done0 at cycle 7.
